// File: rtl/xalu_seq_ctrl_pkg.sv
// Shared encodings and defaults for the mult/div issue controller.
package xalu_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        XOP_MULT  = 3'd0,
        XOP_MULTU = 3'd1,
        XOP_DIV   = 3'd2,
        XOP_DIVU  = 3'd3,
        XOP_MTHI  = 3'd4,
        XOP_MTLO  = 3'd5
    } xop_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2
    } xstate_e;

    localparam int DEF_MUL_LAT = 5;
    localparam int DEF_DIV_LAT = 33;
    localparam int DEF_CNT_W   = 6;

    // Codes above mtlo are reserved and must never be accepted.
    function automatic logic xop_legal(input logic [2:0] code);
        return code <= XOP_MTLO;
    endfunction

endpackage

// File: rtl/xalu_seq_ctrl_if.sv
// Decode/pipeline <-> mult/div controller bundle; master = pipeline side, slave = controller.
interface xalu_seq_ctrl_if;
    import xalu_seq_ctrl_pkg::*;

    logic       op_valid;
    logic [2:0] op_code;
    logic       op_ready;
    logic       intreq;
    logic       flush;
    logic       mf_req;
    logic       unit_start;
    logic       unit_sign;
    logic [1:0] unit_wr_en;
    logic       unit_abort;
    logic       result_sel;
    logic       busy;
    logic       done;
    logic       mf_stall;

    modport master (
        output op_valid, op_code, intreq, flush, mf_req,
        input  op_ready, unit_start, unit_sign, unit_wr_en, unit_abort,
               result_sel, busy, done, mf_stall
    );

    modport slave (
        input  op_valid, op_code, intreq, flush, mf_req,
        output op_ready, unit_start, unit_sign, unit_wr_en, unit_abort,
               result_sel, busy, done, mf_stall
    );
endinterface

// File: rtl/xalu_seq_ctrl_lat.sv
// Loadable latency down-counter; holds at zero and reports it.
module xalu_lat_counter #(
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign zero = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (en && !zero)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Clr)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/xalu_seq_ctrl.sv
// Mult/div issue controller: start pulses, fixed-latency tracking, HI/LO owner, mf interlock.
// Optional: XALU_SEQ_FLUSH_CANCEL_EN lets flush abort an in-flight mult/div.
module xalu_seq_ctrl
    import xalu_seq_ctrl_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic           Clk,
    input  logic           Clr,
    xalu_seq_ctrl_if.slave bus
);
    xstate_e          state_q, state_d;
    logic             sel_q, sel_d;
    logic             op_ready, accept;
    logic             start_c, sign_c, abort_c, done_c;
    logic [1:0]       wr_en_c;
    logic             cnt_load, cnt_en, cnt_zero;
    logic [CNT_W-1:0] cnt_val;
`ifdef XALU_SEQ_FLUSH_CANCEL_EN
    logic             prev_q, prev_d;
`else
    wire              unused_flush = bus.flush;
`endif

    assign op_ready = (state_q == ST_IDLE) && !bus.intreq && !Clr;
    assign accept   = bus.op_valid && op_ready && xop_legal(bus.op_code);

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        start_c  = 1'b0;
        sign_c   = 1'b0;
        wr_en_c  = 2'b00;
        abort_c  = 1'b0;
        done_c   = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_en   = 1'b0;
`ifdef XALU_SEQ_FLUSH_CANCEL_EN
        prev_d   = prev_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.op_code)
                        XOP_MULT, XOP_MULTU: begin
                            start_c  = 1'b1;
                            sign_c   = (bus.op_code == XOP_MULT);
                            state_d  = ST_MUL_RUN;
                            cnt_load = 1'b1;
                            cnt_val  = CNT_W'(MUL_LAT - 1);
                            sel_d    = 1'b1;
`ifdef XALU_SEQ_FLUSH_CANCEL_EN
                            prev_d   = sel_q;
`endif
                        end
                        XOP_DIV, XOP_DIVU: begin
                            start_c  = 1'b1;
                            sign_c   = (bus.op_code == XOP_DIV);
                            state_d  = ST_DIV_RUN;
                            cnt_load = 1'b1;
                            cnt_val  = CNT_W'(DIV_LAT - 1);
                            sel_d    = 1'b0;
`ifdef XALU_SEQ_FLUSH_CANCEL_EN
                            prev_d   = sel_q;
`endif
                        end
                        XOP_MTHI: wr_en_c = 2'b10;
                        XOP_MTLO: wr_en_c = 2'b01;
                        default: ;
                    endcase
                end
            end
            ST_MUL_RUN, ST_DIV_RUN: begin
                cnt_en = 1'b1;
`ifdef XALU_SEQ_FLUSH_CANCEL_EN
                // A cancelled op never produced a result, so HI/LO ownership rolls back.
                if (bus.flush) begin
                    abort_c  = !Clr;
                    state_d  = ST_IDLE;
                    sel_d    = prev_q;
                    cnt_load = 1'b1;
                    cnt_val  = '0;
                end else
`endif
                if (cnt_zero) begin
                    done_c  = !Clr;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
`ifdef XALU_SEQ_FLUSH_CANCEL_EN
            prev_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
`ifdef XALU_SEQ_FLUSH_CANCEL_EN
            prev_q  <= prev_d;
`endif
        end
    end

    xalu_lat_counter #(.CNT_W(CNT_W)) u_lat (
        .Clk      (Clk),
        .Clr      (Clr),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    assign bus.op_ready   = op_ready;
    assign bus.unit_start = start_c;
    assign bus.unit_sign  = sign_c;
    assign bus.unit_wr_en = wr_en_c;
    assign bus.unit_abort = abort_c;
    assign bus.result_sel = sel_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = done_c;
    // The result is valid on the done cycle, so the interlock releases there.
    assign bus.mf_stall   = bus.mf_req && bus.busy && !done_c;
endmodule

// File: tb/tb_xalu_seq_ctrl.sv
// Scoreboard bench for xalu_seq_ctrl: accepted mult/div ops queue their expected done cycle and owner.
module tb_xalu_seq_ctrl;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 33;

    logic Clk = 1'b0;
    logic Clr;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    typedef struct {
        int   at;
        logic sel;
    } exp_t;
    exp_t exp_q[$];

    xalu_seq_ctrl_if bus ();

    xalu_seq_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h cyc=%0d", tag, act, exp, cyc);
        end
    endtask

    // Done monitor: every done pulse must match the oldest outstanding accept.
    always @(negedge Clk) begin
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                chk("done_unexp", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_cyc", cyc, e.at);
                chk("done_sel", bus.result_sel, e.sel);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Present op for one cycle; checks the combinational issue outputs and queues mult/div results.
    task automatic issue(input logic [2:0] code, input logic exp_start, input logic [1:0] exp_wr);
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        @(negedge Clk);
        chk("start", bus.unit_start, exp_start);
        chk("wr_en", bus.unit_wr_en, exp_wr);
        if (exp_start) begin
            chk("sign", bus.unit_sign, (code == 3'd0) || (code == 3'd2));
            exp_q.push_back('{cyc + ((code < 3'd2) ? MUL_LAT : DIV_LAT), code < 3'd2});
        end
        tick();
        bus.op_valid = 1'b0;
    endtask

    // Walk run cycles first..lat after an accept, then the idle cycle that follows done.
    task automatic run_cycles(input int first, input int lat, input logic sel);
        for (int i = first; i <= lat; i++) begin
            @(negedge Clk);
            chk("busy", bus.busy, 1);
            chk("sel", bus.result_sel, sel);
            chk("ready_run", bus.op_ready, 0);
            chk("nostart", bus.unit_start, 0);
            chk("stall", bus.mf_stall, bus.mf_req && (i < lat));
            chk("done_at", bus.done, i == lat);
            tick();
        end
        @(negedge Clk);
        chk("idle_busy", bus.busy, 0);
        chk("idle_ready", bus.op_ready, 1);
    endtask

    task automatic no_done(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            chk("no_done", bus.done, 0);
            chk("no_busy", bus.busy, 0);
            tick();
        end
    endtask

    initial begin
        Clr = 1'b1;
        bus.op_valid = 1'b0;
        bus.op_code  = 3'd0;
        bus.intreq   = 1'b0;
        bus.flush    = 1'b0;
        bus.mf_req   = 1'b0;
        repeat (3) tick();
        @(negedge Clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_sel", bus.result_sel, 0);
        chk("rst_ready", bus.op_ready, 0);
        chk("rst_start", bus.unit_start, 0);
        tick();
        Clr = 1'b0;
        @(negedge Clk);
        chk("post_rst_ready", bus.op_ready, 1);
        tick();

        // signed mult
        issue(3'd0, 1'b1, 2'b00);
        run_cycles(1, MUL_LAT, 1'b1);
        tick();

        // divu with mfhi waiting
        bus.mf_req = 1'b1;
        issue(3'd3, 1'b1, 2'b00);
        run_cycles(1, DIV_LAT, 1'b0);
        tick();
        bus.mf_req = 1'b0;

        // mthi / mtlo never go busy and leave the owner alone
        issue(3'd4, 1'b0, 2'b10);
        @(negedge Clk);
        chk("mthi_busy", bus.busy, 0);
        chk("mthi_sel", bus.result_sel, 0);
        chk("mthi_wr_off", bus.unit_wr_en, 0);
        tick();
        issue(3'd5, 1'b0, 2'b01);
        tick();

        // div, with a mult held by decode throughout the run
        issue(3'd2, 1'b1, 2'b00);
        bus.op_valid = 1'b1;
        bus.op_code  = 3'd0;
        run_cycles(1, DIV_LAT, 1'b0);
        chk("held_start", bus.unit_start, 1);
        chk("held_sign", bus.unit_sign, 1);
        exp_q.push_back('{cyc + MUL_LAT, 1'b1});
        tick();
        bus.op_valid = 1'b0;
        run_cycles(1, MUL_LAT, 1'b1);
        tick();

        // interrupt blocks acceptance
        bus.intreq   = 1'b1;
        bus.op_valid = 1'b1;
        bus.op_code  = 3'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("int_start", bus.unit_start, 0);
            chk("int_ready", bus.op_ready, 0);
            tick();
        end
        bus.intreq = 1'b0;
        issue(3'd1, 1'b1, 2'b00);
        run_cycles(1, MUL_LAT, 1'b1);
        tick();

        // reserved codes do nothing
        issue(3'd6, 1'b0, 2'b00);
        issue(3'd7, 1'b0, 2'b00);
        @(negedge Clk);
        chk("rsv_busy", bus.busy, 0);
        chk("rsv_sel", bus.result_sel, 1);
        tick();

        // reset in the middle of a divide
        issue(3'd2, 1'b1, 2'b00);
        for (int i = 1; i < 10; i++) begin
            @(negedge Clk);
            chk("clr_run_busy", bus.busy, 1);
            tick();
        end
        Clr = 1'b1;
        @(negedge Clk);
        chk("clr_ready", bus.op_ready, 0);
        tick();
        Clr = 1'b0;
        exp_q.delete();
        @(negedge Clk);
        chk("clr_busy", bus.busy, 0);
        chk("clr_sel", bus.result_sel, 0);
        chk("clr_ready_after", bus.op_ready, 1);
        tick();
        no_done(DIV_LAT + 2);

        // mult then div, flush in the 5th div cycle
        issue(3'd0, 1'b1, 2'b00);
        run_cycles(1, MUL_LAT, 1'b1);
        tick();
        issue(3'd2, 1'b1, 2'b00);
        for (int i = 1; i < 5; i++) begin
            @(negedge Clk);
            chk("fl_busy", bus.busy, 1);
            tick();
        end
        bus.flush = 1'b1;
        @(negedge Clk);
`ifdef XALU_SEQ_FLUSH_CANCEL_EN
        chk("abort", bus.unit_abort, 1);
        chk("abort_done", bus.done, 0);
        tick();
        bus.flush = 1'b0;
        exp_q.delete();
        @(negedge Clk);
        chk("fl_idle", bus.busy, 0);
        chk("fl_sel", bus.result_sel, 1);
        tick();
        no_done(DIV_LAT);
`else
        chk("abort", bus.unit_abort, 0);
        chk("fl_still_busy", bus.busy, 1);
        tick();
        bus.flush = 1'b0;
        run_cycles(6, DIV_LAT, 1'b0);
        tick();
`endif

        repeat (3) tick();
        chk("q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/xalu_seq_ctrl.md
Name: xalu_seq_ctrl

Overview:
- Issue/sequencing controller for the multiply/divide unit (mult/div cores plus HI/LO).
- Accepts one HI/LO-class op per handshake from decode and pulses the unit's start.
- Counts fixed per-class latency and tracks which core owns HI/LO.
- Generates busy, done and the mfhi/mflo interlock stall for the pipeline.

Parameters:
- MUL_LAT, 5, cycles from start to mult result valid; must be ≥1.
- DIV_LAT, 33, cycles from start to div result valid; must be ≥1.
- CNT_W, 6, latency counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- Clk  in  1  clock, rising edge.
- Clr  in  1  reset, synchronous, active-high.
- op_valid  in  1  decode presents an op.
- op_code  in  3  0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo; 6,7 reserved.
- op_ready  out  1  controller can accept an op this cycle.
- intreq  in  1  interrupt pending; blocks acceptance this cycle.
- flush  in  1  pipeline flush (see Optional Feature).
- mf_req  in  1  mfhi/mflo in the read stage.
- unit_start  out  1  one-cycle start pulse to the cores.
- unit_sign  out  1  signed op (mult/div), valid with unit_start.
- unit_wr_en  out  2  {hi,lo} write pulse for mthi/mtlo.
- unit_abort  out  1  abort pulse to the cores; tied 0 without the option.
- result_sel  out  1  1 = multiply core drives HI/LO, 0 = divide core.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when the result becomes valid.
- mf_stall  out  1  stall the mfhi/mflo stage.

Behaviour:
- Reset (Clr=1 at an edge): state=IDLE, cnt=0, result_sel=0. All pulse outputs and busy are 0. Reset dominates every other input, including mid-operation; done is not pulsed.
- States: IDLE, MUL_RUN, DIV_RUN.
- op_ready = (state==IDLE) && !intreq && !Clr.
- accept = op_valid && op_ready && op_code ≤ 5. Reserved codes are ignored: no pulse, no state change.
- Accepting mult/multu:
  - unit_start=1 in the same cycle, combinational from accept.
  - unit_sign=(code==0).
  - Next state MUL_RUN, cnt=MUL_LAT-1, result_sel←1.
- Accepting div/divu: same as mult, but unit_sign=(code==2), next state DIV_RUN, cnt=DIV_LAT-1, result_sel←0.
- Accepting mthi/mtlo:
  - unit_wr_en = 2'b10 for mthi or 2'b01 for mtlo, same cycle, combinational.
  - State stays IDLE; result_sel unchanged.
  - busy never asserts.
- RUN states:
  - busy=1; cnt decrements each cycle.
  - When the state is RUN and cnt==0: done=1 for that cycle and the next state is IDLE.
  - A new op can be accepted on the cycle after done. Total start→done = LAT cycles.
- mf_stall = mf_req && busy, combinational. It falls in the same cycle done rises, because done marks the result as valid.
- intreq and op_valid high together: no accept. The op is held by decode.
- result_sel changes only on the edge after a mult/div accept. mthi/mtlo and reset-free idle never change it.
- Counter never wraps: it is loaded only on accept and stops at 0 on leaving RUN.
- unit_start and unit_wr_en are never asserted together.

Optional Feature:
- Macro: XALU_SEQ_FLUSH_CANCEL_EN.
- Defined: flush=1 in MUL_RUN/DIV_RUN gives unit_abort=1 for that cycle and next state IDLE, with no done. Ops are not accepted in a flush cycle.
  - result_sel reverts to its value before the cancelled op. Hold a 1-bit prev_sel register loaded on each mult/div accept.
  - flush in IDLE has no effect.
- Undefined: flush is ignored. In-flight ops always complete, unit_abort is constant 0, and prev_sel is not built.

Decomposition:
- Shared package/header:
  - op_code encodings (XOP_MULT … XOP_MTLO).
  - State encodings (ST_IDLE, ST_MUL_RUN, ST_DIV_RUN).
  - Default latency constants.
- Sub-module xalu_lat_counter:
  - Loadable down-counter with zero flag.
  - Inputs load, load_val, en; output zero.
  - Instantiated once.

Test Plan:
1. Reset then mult (code 0) at cycle 2 → unit_start=1, unit_sign=1 at cycle 2; busy cycles 3–7; done at cycle 7 with MUL_LAT=5; result_sel=1 from cycle 3; op_ready=1 at cycle 8.
2. divu at cycle 2, mf_req held high → mf_stall=1 cycles 3–34, 0 at cycle 35 with done=1 (DIV_LAT=33); unit_sign=0; result_sel=0.
3. mthi in IDLE → unit_wr_en=2'b10 for one cycle; busy stays 0; result_sel unchanged. A mult presented during DIV_RUN is held with op_ready=0 until after done.
4. op_valid with mult while intreq=1 for 3 cycles → no unit_start; accepted on the first cycle intreq=0. Code 6 presented → no outputs change.
5. Clr asserted at cycle 10 of DIV_RUN → next cycle IDLE, busy=0, result_sel=0, no done pulse.
6. With XALU_SEQ_FLUSH_CANCEL_EN: mult, then div, then flush at cycle 5 of the div → unit_abort pulse, no done, result_sel back to 1. Without the macro: the same stimulus completes with done and result_sel=0.
